// File: rtl/gomoku_game_ctrl.sv
// Gomoku turn controller: power-up, board clear, entry, judge, write, end.
// Define GOMOKU_MOVE_TIMEOUT_EN to add the per-move countdown and its port.
module gomoku_game_ctrl #(
    parameter int EDGE_BITS      = 3,
    parameter int START_FLICKERS = 3,
    parameter int SCORE_BITS     = 4,
    parameter int TIMEOUT_SECS   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_power,
    input  logic                   btn_reset,
    input  logic                   btn_ok,
    input  logic                   flicker_tick,
    input  logic                   sec_tick,
    input  logic                   key_valid,
    input  logic [EDGE_BITS:0]     key_index,
    output logic                   key_ready,
    output logic                   memrst_en,
    input  logic                   memrst_done,
    output logic                   judge_en,
    input  logic                   judge_done,
    input  logic [1:0]             judge_result,
    output logic                   ram_we,
    output logic [2*EDGE_BITS-1:0] ram_wr_addr,
    output logic [1:0]             ram_wr_data,
    output logic [2*EDGE_BITS-1:0] pos,
    output logic                   active_side,
    output logic                   screen_flicker_en,
    output logic                   point_flicker_en,
    output logic                   buzzer_en,
    output logic [SCORE_BITS-1:0]  red_wins,
    output logic [SCORE_BITS-1:0]  green_wins,
`ifdef GOMOKU_MOVE_TIMEOUT_EN
    output logic [5:0]             countdown,
`endif
    output logic [2:0]             state_out
);
    localparam int AW = 2 * EDGE_BITS;
    localparam int FW = $clog2(START_FLICKERS + 1);

    typedef enum logic [2:0] {
        S_STOPPED  = 3'd0,
        S_STARTING = 3'd1,
        S_RESET    = 3'd2,
        S_WAIT     = 3'd3,
        S_JUDGE    = 3'd4,
        S_WRITE    = 3'd5,
        S_END      = 3'd6
    } state_t;

    state_t state, state_nx;

    logic                 ok_s1, ok_s2, ok_d, ok_rise;
    logic                 flick_d, flick_rise;
    logic [FW-1:0]        flick_cnt;
    logic [AW-1:0]        piece_count;
    logic [EDGE_BITS-1:0] x_reg, y_reg;
    logic                 x_set, y_set, is_win;
    logic                 take_key, side_tgl, flags_clr;
    logic                 latch_data, score_inc, piece_inc;

    assign ok_rise    = ok_s2 & ~ok_d;
    assign flick_rise = flicker_tick & ~flick_d;

`ifdef GOMOKU_MOVE_TIMEOUT_EN
    logic tmo_reload;
`else
    logic unused_sec_tick;
    assign unused_sec_tick = sec_tick;
`endif

    always_comb begin
        state_nx   = state;
        take_key   = 1'b0;
        side_tgl   = 1'b0;
        flags_clr  = 1'b0;
        latch_data = 1'b0;
        score_inc  = 1'b0;
        piece_inc  = 1'b0;
`ifdef GOMOKU_MOVE_TIMEOUT_EN
        tmo_reload = 1'b0;
`endif
        if (!sw_power) begin
            state_nx = S_STOPPED;
        end else if (btn_reset) begin
            state_nx = S_RESET;
        end else begin
            case (state)
                S_STOPPED:  state_nx = S_STARTING;
                S_STARTING: if (flick_cnt == FW'(START_FLICKERS)) state_nx = S_RESET;
                S_RESET:    if (memrst_done) state_nx = S_WAIT;
                S_WAIT: begin
                    take_key = key_valid;
                    if (x_set && y_set && ok_rise) begin
                        state_nx = S_JUDGE;
                    end
`ifdef GOMOKU_MOVE_TIMEOUT_EN
                    else if (sec_tick && countdown <= 6'd1) begin
                        side_tgl   = 1'b1;
                        flags_clr  = 1'b1;
                        tmo_reload = 1'b1;
                    end
`endif
                end
                S_JUDGE: begin
                    if (judge_done) begin
                        if (judge_result == 2'b01 || judge_result == 2'b10) begin
                            latch_data = 1'b1;
                            state_nx   = S_WRITE;
                        end else begin
                            // illegal move forfeits the turn
                            side_tgl  = 1'b1;
                            flags_clr = 1'b1;
                            state_nx  = S_WAIT;
                        end
                    end
                end
                S_WRITE: begin
                    if (is_win) begin
                        score_inc = 1'b1;
                        state_nx  = S_END;
                    end else if (&piece_count) begin
                        state_nx = S_END;
                    end else begin
                        piece_inc = 1'b1;
                        side_tgl  = 1'b1;
                        flags_clr = 1'b1;
                        state_nx  = S_WAIT;
                    end
                end
                S_END:   state_nx = S_END;
                default: state_nx = S_STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_STOPPED;
            ok_s1       <= 1'b0;
            ok_s2       <= 1'b0;
            ok_d        <= 1'b0;
            flick_d     <= 1'b0;
            flick_cnt   <= '0;
            piece_count <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            x_set       <= 1'b0;
            y_set       <= 1'b0;
            is_win      <= 1'b0;
            active_side <= 1'b0;
            ram_wr_data <= 2'b00;
            red_wins    <= '0;
            green_wins  <= '0;
            key_ready   <= 1'b0;
        end else begin
            state     <= state_nx;
            ok_s1     <= btn_ok;
            ok_s2     <= ok_s1;
            ok_d      <= ok_s2;
            flick_d   <= flicker_tick;
            key_ready <= key_valid;
            if (state != S_STARTING) begin
                flick_cnt <= '0;
            end else if (flick_rise && flick_cnt != FW'(START_FLICKERS)) begin
                flick_cnt <= flick_cnt + 1'b1;
            end
            if (state == S_RESET) begin
                active_side <= 1'b0;
                piece_count <= '0;
                x_set       <= 1'b0;
                y_set       <= 1'b0;
            end else begin
                if (side_tgl) active_side <= ~active_side;
                if (piece_inc) piece_count <= piece_count + 1'b1;
                if (flags_clr) begin
                    x_set <= 1'b0;
                    y_set <= 1'b0;
                end else if (take_key) begin
                    if (key_index[EDGE_BITS]) begin
                        x_reg <= key_index[EDGE_BITS-1:0];
                        x_set <= 1'b1;
                    end else begin
                        y_reg <= key_index[EDGE_BITS-1:0];
                        y_set <= 1'b1;
                    end
                end
            end
            if (latch_data) begin
                ram_wr_data <= active_side ? 2'b10 : 2'b01;
                is_win      <= judge_result[1];
            end
            if (score_inc) begin
                if (!active_side) begin
                    if (!(&red_wins)) red_wins <= red_wins + 1'b1;
                end else begin
                    if (!(&green_wins)) green_wins <= green_wins + 1'b1;
                end
            end
        end
    end

`ifdef GOMOKU_MOVE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            countdown <= 6'd0;
        end else if (state_nx == S_WAIT && (state != S_WAIT || tmo_reload)) begin
            countdown <= 6'(TIMEOUT_SECS);
        end else if (state == S_WAIT && state_nx == S_WAIT && sec_tick) begin
            countdown <= countdown - 1'b1;
        end
    end
`endif

    assign pos               = {y_reg, x_reg};
    assign ram_we            = (state == S_WRITE);
    assign ram_wr_addr       = ram_we ? pos : '0;
    assign memrst_en         = (state == S_RESET);
    assign judge_en          = (state == S_JUDGE);
    assign screen_flicker_en = (state == S_STARTING);
    assign point_flicker_en  = (state == S_WAIT) && x_set && y_set;
    assign buzzer_en         = (state == S_END);
    assign state_out         = state;

endmodule

// File: tb/tb_gomoku_game_ctrl.sv
// Directed bench for gomoku_game_ctrl: move table plus multi-cycle sequences.
// Covers the countdown too when GOMOKU_MOVE_TIMEOUT_EN is defined.
module tb_gomoku_game_ctrl;
    logic       clk = 1'b0;
    logic       rst, sw_power, btn_reset, btn_ok, flicker_tick, sec_tick;
    logic       key_valid, memrst_done, judge_done;
    logic [3:0] key_index;
    logic [1:0] judge_result;
    logic       key_ready, memrst_en, judge_en, ram_we;
    logic [5:0] ram_wr_addr, pos;
    logic [1:0] ram_wr_data;
    logic       active_side, screen_flicker_en, point_flicker_en, buzzer_en;
    logic [3:0] red_wins, green_wins;
    logic [2:0] state_out;
`ifdef GOMOKU_MOVE_TIMEOUT_EN
    logic [5:0] countdown;
`endif

    int checks = 0;
    int fails  = 0;
    int bad_we = 0;

    always #5 clk = ~clk;

    gomoku_game_ctrl dut (
        .clk(clk), .rst(rst), .sw_power(sw_power), .btn_reset(btn_reset),
        .btn_ok(btn_ok), .flicker_tick(flicker_tick), .sec_tick(sec_tick),
        .key_valid(key_valid), .key_index(key_index), .key_ready(key_ready),
        .memrst_en(memrst_en), .memrst_done(memrst_done), .judge_en(judge_en),
        .judge_done(judge_done), .judge_result(judge_result), .ram_we(ram_we),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .pos(pos),
        .active_side(active_side), .screen_flicker_en(screen_flicker_en),
        .point_flicker_en(point_flicker_en), .buzzer_en(buzzer_en),
        .red_wins(red_wins), .green_wins(green_wins),
`ifdef GOMOKU_MOVE_TIMEOUT_EN
        .countdown(countdown),
`endif
        .state_out(state_out)
    );

    always @(negedge clk) if (ram_we && state_out != 3'd5) bad_we++;

    typedef struct {
        logic [2:0] x;
        logic [2:0] y;
        logic [1:0] res;
        logic       we;
        logic [5:0] addr;
        logic [1:0] data;
        logic       side;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_st(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (state_out !== s && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(state_out), 32'(s));
    endtask

    task automatic do_keys(input logic [2:0] x, input logic [2:0] y);
        key_valid = 1'b1;
        key_index = {1'b1, x};
        tick();
        key_index = {1'b0, y};
        tick();
        key_valid = 1'b0;
        tick();
    endtask

    task automatic confirm(input string name);
        btn_ok = 1'b1;
        wait_st(3'd4, 8, name);
        btn_ok = 1'b0;
    endtask

    task automatic judge(input logic [1:0] res, output logic we,
                         output logic [5:0] addr, output logic [1:0] data);
        judge_done   = 1'b1;
        judge_result = res;
        tick();
        judge_done = 1'b0;
        we   = ram_we;
        addr = ram_wr_addr;
        data = ram_wr_data;
        tick();
    endtask

    task automatic move(input logic [2:0] x, input logic [2:0] y, input logic [1:0] res,
                        output logic we, output logic [5:0] addr, output logic [1:0] data);
        do_keys(x, y);
        confirm("to_judge");
        judge(res, we, addr, data);
    endtask

    task automatic new_round(input string name);
        btn_reset = 1'b1;
        tick();
        btn_reset   = 1'b0;
        memrst_done = 1'b1;
        tick();
        memrst_done = 1'b0;
        wait_st(3'd3, 4, name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       we;
        logic [5:0] addr;
        logic [1:0] data;

        vecs[0] = '{3'd5, 3'd2, 2'b01, 1'b1, 6'b010101, 2'b01, 1'b1, 3'd3};
        vecs[1] = '{3'd3, 3'd3, 2'b00, 1'b0, 6'b000000, 2'b00, 1'b0, 3'd3};
        vecs[2] = '{3'd0, 3'd7, 2'b01, 1'b1, 6'b111000, 2'b01, 1'b1, 3'd3};
        vecs[3] = '{3'd7, 3'd0, 2'b01, 1'b1, 6'b000111, 2'b10, 1'b0, 3'd3};
        vecs[4] = '{3'd1, 3'd1, 2'b00, 1'b0, 6'b000000, 2'b00, 1'b1, 3'd3};
        vecs[5] = '{3'd4, 3'd6, 2'b10, 1'b1, 6'b110100, 2'b10, 1'b1, 3'd6};

        rst = 1'b1; sw_power = 1'b0; btn_reset = 1'b0; btn_ok = 1'b0;
        flicker_tick = 1'b0; sec_tick = 1'b0; key_valid = 1'b0; key_index = 4'd0;
        memrst_done = 1'b0; judge_done = 1'b0; judge_result = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_side", 32'(active_side), 32'd0);
        chk("rst_scores", 32'({red_wins, green_wins}), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);

        sw_power = 1'b1;
        tick();
        chk("starting", 32'(state_out), 32'd1);
        chk("screen_flicker_on", 32'(screen_flicker_en), 32'd1);
        for (int i = 0; i < 2; i++) begin
            flicker_tick = 1'b1;
            tick();
            tick();
            flicker_tick = 1'b0;
            tick();
            tick();
        end
        chk("two_flickers_still_starting", 32'(state_out), 32'd1);
        flicker_tick = 1'b1;
        wait_st(3'd2, 6, "third_flicker_reset");
        flicker_tick = 1'b0;
        chk("screen_flicker_off", 32'(screen_flicker_en), 32'd0);
        chk("memrst_en", 32'(memrst_en), 32'd1);
        memrst_done = 1'b1;
        tick();
        memrst_done = 1'b0;
        chk("wait_after_clear", 32'(state_out), 32'd3);
        chk("red_first", 32'(active_side), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_keys(vecs[i].x, vecs[i].y);
            chk($sformatf("v%0d_point_flicker", i), 32'(point_flicker_en), 32'd1);
            confirm($sformatf("v%0d_judge", i));
            chk($sformatf("v%0d_judge_en", i), 32'(judge_en), 32'd1);
            judge(vecs[i].res, we, addr, data);
            chk($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("v%0d_addr", i), 32'(addr), 32'(vecs[i].addr));
                chk($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].data));
            end
            chk($sformatf("v%0d_we_off", i), 32'(ram_we), 32'd0);
            chk($sformatf("v%0d_side", i), 32'(active_side), 32'(vecs[i].side));
            chk($sformatf("v%0d_state", i), 32'(state_out), 32'(vecs[i].st));
            chk($sformatf("v%0d_point_off", i), 32'(point_flicker_en), 32'd0);
        end
        chk("win_green", 32'(green_wins), 32'd1);
        chk("win_red", 32'(red_wins), 32'd0);
        chk("buzzer", 32'(buzzer_en), 32'd1);

        key_valid = 1'b1;
        key_index = 4'b1010;
        tick();
        key_valid = 1'b0;
        chk("key_ready_in_end", 32'(key_ready), 32'd1);
        tick();
        chk("key_ignored_in_end", 32'(pos), 32'o64);

        btn_reset = 1'b1;
        tick();
        btn_reset = 1'b0;
        chk("btn_reset_state", 32'(state_out), 32'd2);
        chk("btn_reset_keeps_score", 32'(green_wins), 32'd1);
        memrst_done = 1'b1;
        tick();
        memrst_done = 1'b0;

        key_valid = 1'b1;
        key_index = 4'b1001;
        tick();
        key_valid = 1'b0;
        btn_ok    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        btn_ok = 1'b0;
        chk("confirm_missing_flag", 32'(state_out), 32'd3);
        move(3'd6, 3'd4, 2'b01, we, addr, data);
        chk("last_key_wins_addr", 32'(addr), 32'b100110);
        chk("last_key_wins_data", 32'(data), 32'b01);

        new_round("full_round");
        for (int i = 0; i < 64; i++) begin
            logic [5:0] c;
            c = 6'(i);
            move(c[2:0], c[5:3], 2'b01, we, addr, data);
            if (i == 62) chk("move63_wait", 32'(state_out), 32'd3);
        end
        chk("board_full_end", 32'(state_out), 32'd6);
        chk("draw_green", 32'(green_wins), 32'd1);
        chk("draw_red", 32'(red_wins), 32'd0);

        for (int r = 0; r < 14; r++) begin
            new_round("win_round");
            move(3'd0, 3'd0, 2'b01, we, addr, data);
            move(3'd1, 3'd0, 2'b10, we, addr, data);
        end
        chk("green_15", 32'(green_wins), 32'd15);
        new_round("sat_round");
        move(3'd0, 3'd0, 2'b01, we, addr, data);
        move(3'd1, 3'd0, 2'b10, we, addr, data);
        chk("green_saturates", 32'(green_wins), 32'd15);
        chk("sat_end", 32'(state_out), 32'd6);

`ifdef GOMOKU_MOVE_TIMEOUT_EN
        new_round("tmo_round");
        chk("tmo_load", 32'(countdown), 32'd15);
        for (int k = 0; k < 15; k++) begin
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
            tick();
            if (k == 4) chk("tmo_count", 32'(countdown), 32'd10);
        end
        chk("tmo_toggle", 32'(active_side), 32'd1);
        chk("tmo_reload", 32'(countdown), 32'd15);
        chk("tmo_state", 32'(state_out), 32'd3);
`endif

        new_round("pwr_round");
        do_keys(3'd2, 3'd2);
        confirm("pwr_judge");
        sw_power = 1'b0;
        tick();
        chk("pwr_off_state", 32'(state_out), 32'd0);
        judge_done   = 1'b1;
        judge_result = 2'b01;
        tick();
        judge_done = 1'b0;
        chk("pwr_off_no_we", 32'(ram_we), 32'd0);
        chk("pwr_off_scores", 32'(green_wins), 32'd15);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_clears_scores", 32'({red_wins, green_wins}), 32'd0);
        chk("we_only_in_write", 32'(bad_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/gomoku_game_ctrl.md
Name: gomoku_game_ctrl

Overview:
- Parametrised next-generation turn controller for the Gomoku/board-game top level. Board edge is a parameter.
- Sequences power-up flicker, board clear, coordinate entry, judging, piece write and end-of-game.
- Keeps per-side win scores across rounds and an optional per-move countdown.
- Drives external RAM-clear, judger, LED scanner and buzzer blocks through handshake ports.

Parameters:
EDGE_BITS, 3, log2 of board edge; board has 2^(2*EDGE_BITS) cells.
START_FLICKERS, 3, flicker_tick rising edges counted in STARTING before clearing.
SCORE_BITS, 4, width of each saturating win counter.
TIMEOUT_SECS, 15, per-move countdown load value; used only with the optional feature.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sw_power  in  1  level; 0 forces STOPPED
btn_reset  in  1  level; forces RESET (new round, scores kept)
btn_ok  in  1  raw level; 2-FF synchronised; rising edge = confirm
flicker_tick  in  1  slow flicker level; rising edges counted
sec_tick  in  1  one-cycle 1 Hz pulse (countdown only)
key_valid  in  1  keyboard has key
key_index  in  EDGE_BITS+1  MSB=1 x-coordinate, MSB=0 y-coordinate; low bits = value
key_ready  out  1  registered; 1 the cycle after key_valid seen
memrst_en  out  1  high in RESET
memrst_done  in  1  clear finished
judge_en  out  1  high in JUDGE
judge_done  in  1  judger result strobe
judge_result  in  2  00 invalid, 01 valid, 10 win
ram_we  out  1  one-cycle write strobe
ram_wr_addr  out  2*EDGE_BITS  {y,x}
ram_wr_data  out  2  01 red, 10 green
pos  out  2*EDGE_BITS  current {y,x}
active_side  out  1  0 red, 1 green
screen_flicker_en  out  1  state==STARTING
point_flicker_en  out  1  WAIT and both coordinates entered
buzzer_en  out  1  state==END
red_wins, green_wins  out  SCORE_BITS each  saturating scores
state_out  out  3  current state encoding

Behaviour:
- States: STOPPED=0, STARTING=1, RESET=2, WAIT=3, JUDGE=4, WRITE=5, END=6. Unused codes go to STOPPED.
- Reset state: STOPPED. Outputs 0, except pos=0, active_side=0 and scores=0.
- Transition precedence: ~sw_power -> STOPPED; else btn_reset -> RESET; else normal transitions.
- STOPPED->STARTING when sw_power=1. Entering STARTING clears the flicker counter.
- STARTING->RESET once START_FLICKERS rising edges of flicker_tick have been counted.
- RESET: active_side<=0, piece_count<=0, pressed flags<=0. RESET->WAIT on memrst_done.
- WAIT, key_valid: low bits load x (MSB=1) or y (MSB=0) and set the matching pressed flag. Re-entry overwrites; last key wins.
- Keys are accepted only in WAIT. key_ready is a registered copy of key_valid in every state.
- WAIT->JUDGE when both flags are set and a btn_ok rising edge occurs in the same cycle. A confirm with a missing flag is ignored.
- JUDGE on judge_done:
  - result 01 or 10: latch ram_wr_data from active_side and go to WRITE.
  - result 00: toggle active_side, clear the flags, go to WAIT. Illegal moves forfeit the turn, as in the current product.
- WRITE (exactly 1 cycle): ram_we=1, ram_wr_addr=pos.
  - Win: increment the active side's score (saturates at all-ones); go to END.
  - Valid and piece_count==2^(2*EDGE_BITS)-1 (board full, draw): go to END, no score change.
  - Otherwise: piece_count+1, toggle active_side, clear flags, go to WAIT.
- END holds until btn_reset or ~sw_power.
- ram_we is never high outside WRITE. Memory clear is driven externally on the separate memrst port.
- Scores clear only on rst; btn_reset and power-off keep them.
- rst mid-JUDGE/WRITE: abort immediately; no write issued.

Optional Feature:
- Macro: GOMOKU_MOVE_TIMEOUT_EN.
- With the macro:
  - 6-bit countdown output port countdown[5:0].
  - Loads TIMEOUT_SECS on every entry to WAIT; decrements on sec_tick while in WAIT.
  - Reaching 0 in WAIT: toggle active_side, clear flags, reload; no write, no piece_count change.
  - Countdown frozen outside WAIT.
- Without the macro: port absent, no timeout logic, sec_tick ignored.

Test Plan:
- Power up, 3 flicker_tick edges, memrst_done pulse -> state_out 1->2->3; screen_flicker_en high only in 1; active_side=0.
- Keys x=5 (index 1101), y=2 (0010), btn_ok, judge_result=01 -> one-cycle ram_we, addr=6'o25 (010101), data=01; then active_side=1, state 3.
- Judge returns 00 -> no ram_we, active_side toggles, point_flicker_en=0, state 3.
- Judge returns 10 with active_side=1 -> write data=10, green_wins 0->1, state 6, buzzer_en=1; btn_reset -> state 2, green_wins stays 1.
- 63 valid moves then 64th valid -> state 6, scores unchanged; green_wins preset to 15 plus a win -> stays 15.
- Timeout build: no input for 15 sec_ticks -> active_side toggles, countdown reloads 15; sw_power=0 mid-JUDGE -> state 0, ram_we never asserted.
